// File: rtl/key_debounce_if.sv
// Key debounce signal bundle: raw keys in, clean levels and strobes out.
// glitch_cnt exists only with KEY_DEBOUNCE_GLITCH_CNT_EN.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] KEY_out;
  logic [N_KEYS-1:0] KEY_chg;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;

  modport master (
    output KEY,
    input  KEY_out,
    input  KEY_chg,
    input  glitch_cnt
  );

  modport slave (
    input  KEY,
    output KEY_out,
    output KEY_chg,
    output glitch_cnt
  );
`else
  modport master (
    output KEY,
    input  KEY_out,
    input  KEY_chg
  );

  modport slave (
    input  KEY,
    output KEY_out,
    output KEY_chg
  );
`endif
endinterface

// File: rtl/key_debounce.sv
// Pushbutton synchronizer and per-key stability filter.
// Optional bounce counter: KEY_DEBOUNCE_GLITCH_CNT_EN.
module key_debounce #(
  parameter  int N_KEYS        = 4,
  parameter  int STABLE_CYCLES = 250000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave kb
);

  typedef enum logic {
    IDLE,
    COUNTING
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] out_q;
  logic [N_KEYS-1:0] out_d;
  logic [N_KEYS-1:0] chg_q;
  logic [N_KEYS-1:0] chg_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  state_t            st    [N_KEYS];
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  logic [N_KEYS-1:0] bounce;
  logic [7:0]        glitch_q;
  logic [7:0]        glitch_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '1;
      s2    <= '1;
      out_q <= '1;
      chg_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1    <= kb.KEY;
      s2    <= s1;
      out_q <= out_d;
      chg_q <= chg_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Any sample equal to the held level sends the key back to IDLE.
  always_comb begin
    out_d = out_q;
    chg_d = '0;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    bounce = '0;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      st[i] = (cnt_q[i] == '0) ? IDLE : COUNTING;
      unique case (st[i])
        IDLE: begin
          if (s2[i] != out_q[i]) begin
            if (LAST == '0) begin
              out_d[i] = s2[i];
              chg_d[i] = 1'b1;
            end else begin
              cnt_d[i] = CNT_W'(1);
            end
          end
        end
        COUNTING: begin
          if (s2[i] != out_q[i]) begin
            if (cnt_q[i] == LAST) begin
              out_d[i] = s2[i];
              chg_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end else begin
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
            bounce[i] = 1'b1;
`endif
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign kb.KEY_out = out_q;
  assign kb.KEY_chg = chg_q;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  always_comb begin
    int unsigned sum;
    sum = 32'(glitch_q);
    for (int i = 0; i < N_KEYS; i++) begin
      sum = sum + 32'(bounce[i]);
    end
    glitch_d = (sum > 32'd255) ? 8'hff : sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign kb.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, corner sequences, random vs model.
// Glitch counter checks are active with KEY_DEBOUNCE_GLITCH_CNT_EN.
module tb_key_debounce;

  localparam int N = 2;
  localparam int S = 4;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  key_debounce_if #(.N_KEYS(N)) kif ();

  key_debounce #(
    .N_KEYS       (N),
    .STABLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kb   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level is accepted once the last S sampled values all
  // differ from the held level; a glitch is a mismatch run ended by a match.
  logic [1:0] ms1;
  logic [1:0] ms2;
  logic [1:0] mout;
  logic [1:0] mchg;
  bit         mcommit [N];
  bit         hist    [N][$];
  int         mgl;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms1  = 2'b11;
      ms2  = 2'b11;
      mout = 2'b11;
      mchg = 2'b00;
      mgl  = 0;
      for (int i = 0; i < N; i++) begin
        mcommit[i] = 1'b0;
        hist[i].delete();
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit v;
        bit win;
        int n;
        v = ms2[i];
        mchg[i] = 1'b0;
        hist[i].push_back(v);
        n = hist[i].size();
        win = (n >= S);
        if (win) begin
          for (int j = 0; j < S; j++) begin
            if (hist[i][n-1-j] == mout[i]) win = 1'b0;
          end
        end
        if (win) begin
          mout[i] = v;
          mchg[i] = 1'b1;
        end else if (v == mout[i] && n >= 2 && !mcommit[i]
                     && hist[i][n-2] != mout[i]) begin
          if (mgl < 255) mgl = mgl + 1;
        end
        mcommit[i] = win;
        if (n > S + 2) void'(hist[i].pop_front());
      end
      ms2 = ms1;
      ms1 = kif.KEY;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_chk();
    chk("model_out", 8'(kif.KEY_out), 8'(mout));
    chk("model_chg", 8'(kif.KEY_chg), 8'(mchg));
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    chk("model_glitch", kif.glitch_cnt, 8'(mgl));
`endif
  endtask

  task automatic cyc(input logic [1:0] k);
    kif.KEY = k;
    @(negedge clk);
    model_chk();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] key;
    logic [1:0] out;
    logic [1:0] chg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] k, input logic [1:0] o,
                     input logic [1:0] c, input int n);
    vec_t v;
    v.key = k;
    v.out = o;
    v.chg = c;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [1:0] cur;
    int         hold [N];
    total    = 0;
    passed   = 0;
    reset    = 1'b0;
    kif.KEY  = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_out", 8'(kif.KEY_out), 8'h03);
    chk("rst_chg", 8'(kif.KEY_chg), 8'h00);
    reset = 1'b1;
    cyc(2'b11);

    // clean press / release of key 0
    add(2'b10, 2'b11, 2'b00, 5);
    add(2'b10, 2'b10, 2'b01, 1);
    add(2'b10, 2'b10, 2'b00, 1);
    add(2'b11, 2'b10, 2'b00, 5);
    add(2'b11, 2'b11, 2'b01, 1);
    add(2'b11, 2'b11, 2'b00, 1);
    // 3-sample bounce is rejected
    add(2'b10, 2'b11, 2'b00, 3);
    add(2'b11, 2'b11, 2'b00, 5);
    // bounce then settle: commit 5 edges after last fall
    add(2'b10, 2'b11, 2'b00, 2);
    add(2'b11, 2'b11, 2'b00, 1);
    add(2'b10, 2'b11, 2'b00, 5);
    add(2'b10, 2'b10, 2'b01, 1);
    add(2'b10, 2'b10, 2'b00, 1);
    add(2'b11, 2'b10, 2'b00, 5);
    add(2'b11, 2'b11, 2'b01, 1);
    add(2'b11, 2'b11, 2'b00, 1);
    // both keys together
    add(2'b00, 2'b11, 2'b00, 5);
    add(2'b00, 2'b00, 2'b11, 1);
    add(2'b00, 2'b00, 2'b00, 1);
    add(2'b11, 2'b00, 2'b00, 5);
    add(2'b11, 2'b11, 2'b11, 1);
    add(2'b11, 2'b11, 2'b00, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].key);
      chk($sformatf("tbl%0d_out", i), 8'(kif.KEY_out), 8'(tbl[i].out));
      chk($sformatf("tbl%0d_chg", i), 8'(kif.KEY_chg), 8'(tbl[i].chg));
    end
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    chk("tbl_glitch", kif.glitch_cnt, 8'd2);
`endif

    // async reset while a strobe is high
    repeat (5) cyc(2'b10);
    cyc(2'b10);
    chk("pre_rst_chg", 8'(kif.KEY_chg), 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out", 8'(kif.KEY_out), 8'h03);
    chk("async_rst_chg", 8'(kif.KEY_chg), 8'h00);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    chk("async_rst_glitch", kif.glitch_cnt, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // reset mid-count on key 1, then the full latency again
    repeat (3) cyc(2'b01);
    pulse_reset();
    chk("midcnt_out", 8'(kif.KEY_out), 8'h03);
    repeat (5) begin
      cyc(2'b01);
      chk("post_rst_hold", 8'(kif.KEY_out), 8'h03);
    end
    cyc(2'b01);
    chk("post_rst_out", 8'(kif.KEY_out), 8'h01);
    chk("post_rst_chg", 8'(kif.KEY_chg), 8'h02);

    // 300 single-sample glitches
    pulse_reset();
    kif.KEY = 2'b11;
    repeat (300) begin
      cyc(2'b10);
      cyc(2'b11);
    end
    cyc(2'b11);
    chk("sat_out", 8'(kif.KEY_out), 8'h03);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    chk("sat_glitch", kif.glitch_cnt, 8'd255);
`endif

    // random bouncing against the model
    pulse_reset();
    cur = 2'b11;
    for (int i = 0; i < N; i++) hold[i] = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          cur[i]  = ~cur[i];
          hold[i] = $urandom_range(1, 7);
        end
      end
      cyc(cur);
      if (c == 300) pulse_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
